// File: rtl/jtframe_cen_pkg.sv
// ----------------------------------------------------------------------------
// jtframe_cen_pkg
// Shared constants and helpers for the multi-channel fractional clock-enable
// generator (jtframe_multi_cen / jtframe_cen_ch).
//   MAX_CH : largest channel count the configuration port can address
//   CH_W   : width of the configuration channel selector
// ----------------------------------------------------------------------------
package jtframe_cen_pkg;

  localparam int MAX_CH = 8;
  localparam int CH_W   = 3;

  // True when the configuration selector addresses channel k
  function automatic logic ch_match(input logic [CH_W-1:0] ch, input int k);
    return (ch == CH_W'(k));
  endfunction

endpackage

// File: rtl/jtframe_cen_ch.sv
// ----------------------------------------------------------------------------
// jtframe_cen_ch
// One fractional clock-enable channel. An accumulator adds n every unpaused
// cycle and wraps modulo m, producing cen at an average rate of f_clk*n/m.
// A shadow n/m pair holds a newly written ratio until the channel reaches a
// cen pulse (or immediately when the channel is silent), so ratio changes
// never cut a period short.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   pause         : freeze accumulator/toggle/apply, suppress pulses
//   we            : write strobe for this channel's shadow ratio
//   wr_n, wr_m    : ratio written into the shadow registers
//   cen           : one-cycle enable at rate n/m
//   cen2          : every second cen (first one after reset/apply included)
//   cenb          : one-cycle enable half-way between cen pulses
//   pend          : a shadow ratio is waiting to be applied
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module jtframe_cen_ch
  import jtframe_cen_pkg::*;
#(
  parameter int            WC     = 10,
  parameter logic [WC-1:0] INIT_N = {{(WC-1){1'b0}}, 1'b1},
  parameter logic [WC-1:0] INIT_M = {{(WC-3){1'b0}}, 3'b100}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pause,
  input  logic          we,
  input  logic [WC-1:0] wr_n,
  input  logic [WC-1:0] wr_m,
  output logic          cen,
  output logic          cen2,
  output logic          cenb,
  output logic          pend
);

  logic [WC-1:0] n_r, m_r, sh_n_r, sh_m_r, acc_r;
  logic          tog_r, pend_r, cen_r, cen2_r, cenb_r;

  logic [WC:0]   sum_s, m_ext_s, half_s;
  logic [WC-1:0] diff_s;
  logic          silent_s, fast_s, hit_s, cenb_s, apply_s;

  logic [WC-1:0] n_d, m_d, sh_n_d, sh_m_d, acc_d;
  logic          tog_d, pend_d, cen_d, cen2_d, cenb_d;

  // Accumulator decision: sum is one bit wider so acc+n never overflows
  always_comb begin
    sum_s    = {1'b0, acc_r} + {1'b0, n_r};
    m_ext_s  = {1'b0, m_r};
    half_s   = m_ext_s >> 1;
    // sum-m is below m whenever it is used, so the low WC bits are exact
    diff_s   = sum_s[WC-1:0] - m_r;
    silent_s = (n_r == {WC{1'b0}}) || (m_r == {WC{1'b0}});
    fast_s   = !silent_s && (n_r >= m_r);
    hit_s    = !silent_s && (sum_s >= m_ext_s);
    cenb_s   = !silent_s && !fast_s && !hit_s &&
               ({1'b0, acc_r} < half_s) && (sum_s >= half_s);
    apply_s  = !pause && pend_r && (hit_s || silent_s);
  end

  // Next-state selection for accumulator, toggle, ratio and pending flag
  always_comb begin
    if (pause) begin
      acc_d = acc_r;
      tog_d = tog_r;
    end else if (apply_s) begin
      acc_d = {WC{1'b0}};
      tog_d = 1'b0;
    end else if (silent_s) begin
      acc_d = acc_r;
      tog_d = tog_r;
    end else if (fast_s) begin
      acc_d = {WC{1'b0}};
      tog_d = ~tog_r;
    end else if (hit_s) begin
      acc_d = diff_s;
      tog_d = ~tog_r;
    end else begin
      acc_d = sum_s[WC-1:0];
      tog_d = tog_r;
    end

    if (apply_s) begin
      n_d = sh_n_r;
      m_d = sh_m_r;
    end else begin
      n_d = n_r;
      m_d = m_r;
    end

    // A write in the same cycle as an apply keeps the new ratio pending
    if (we) begin
      sh_n_d = wr_n;
      sh_m_d = wr_m;
      pend_d = 1'b1;
    end else if (apply_s) begin
      sh_n_d = sh_n_r;
      sh_m_d = sh_m_r;
      pend_d = 1'b0;
    end else begin
      sh_n_d = sh_n_r;
      sh_m_d = sh_m_r;
      pend_d = pend_r;
    end

    // The apply cycle still issues its pulse under the old ratio and toggle
    cen_d  = !pause && hit_s;
    cen2_d = !pause && hit_s && !tog_r;
    cenb_d = !pause && cenb_s;
  end

  // Channel state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r    <= INIT_N;
      m_r    <= INIT_M;
      sh_n_r <= INIT_N;
      sh_m_r <= INIT_M;
      acc_r  <= {WC{1'b0}};
      tog_r  <= 1'b0;
      pend_r <= 1'b0;
      cen_r  <= 1'b0;
      cen2_r <= 1'b0;
      cenb_r <= 1'b0;
    end else begin
      n_r    <= n_d;
      m_r    <= m_d;
      sh_n_r <= sh_n_d;
      sh_m_r <= sh_m_d;
      acc_r  <= acc_d;
      tog_r  <= tog_d;
      pend_r <= pend_d;
      cen_r  <= cen_d;
      cen2_r <= cen2_d;
      cenb_r <= cenb_d;
    end
  end

  assign cen  = cen_r;
  assign cen2 = cen2_r;
  assign cenb = cenb_r;
  assign pend = pend_r;

endmodule

// File: rtl/jtframe_multi_cen.sv
// ----------------------------------------------------------------------------
// jtframe_multi_cen
// NCH independent fractional clock-enable generators sharing one clock and a
// single configuration write port. Each channel k produces cen at an average
// rate f_clk*n_k/m_k plus half-rate (cen2) and mid-period (cenb) enables.
// Parameters:
//   NCH    : channel count, 1..8
//   WC     : width of n, m and the accumulator (at least 3)
//   INIT_N : packed reset numerators, channel k in [k*WC +: WC]
//   INIT_M : packed reset denominators, same packing
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   pause             : hold all channels, no pulses
//   cfg_we/ch/n/m     : write a new ratio to channel cfg_ch (>= NCH ignored)
//   cfg_pend[NCH]     : written ratio awaiting application
//   cen/cen2/cenb[NCH]: registered enable pulses
// Optional feature (macro JTFRAME_MULTI_CEN_CNT_EN):
//   cnt_clr           : synchronous clear of all pulse counters
//   cen_cnt[NCH*16]   : wrapping per-channel cen pulse counters
// ----------------------------------------------------------------------------
module jtframe_multi_cen
  import jtframe_cen_pkg::*;
#(
  parameter int                NCH    = 4,
  parameter int                WC     = 10,
  parameter logic [NCH*WC-1:0] INIT_N = {NCH{{{(WC-1){1'b0}}, 1'b1}}},
  parameter logic [NCH*WC-1:0] INIT_M = {NCH{{{(WC-3){1'b0}}, 3'b100}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WC-1:0]    cfg_n,
  input  logic [WC-1:0]    cfg_m,
  output logic [NCH-1:0]   cfg_pend,
  output logic [NCH-1:0]   cen,
  output logic [NCH-1:0]   cen2,
  output logic [NCH-1:0]   cenb
`ifdef JTFRAME_MULTI_CEN_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [NCH*16-1:0] cen_cnt
`endif
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic we_s;

    // Channel selectors beyond NCH-1 never match, so such writes are dropped
    assign we_s = cfg_we && ch_match(cfg_ch, k);

    jtframe_cen_ch #(
      .WC     (WC),
      .INIT_N (INIT_N[k*WC +: WC]),
      .INIT_M (INIT_M[k*WC +: WC])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .pause (pause),
      .we    (we_s),
      .wr_n  (cfg_n),
      .wr_m  (cfg_m),
      .cen   (cen[k]),
      .cen2  (cen2[k]),
      .cenb  (cenb[k]),
      .pend  (cfg_pend[k])
    );

`ifdef JTFRAME_MULTI_CEN_CNT_EN
    logic [15:0] cnt_r;

    // Wrapping count of issued cen pulses for this channel
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r <= 16'd0;
      end else if (cnt_clr) begin
        cnt_r <= 16'd0;
      end else if (cen[k]) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign cen_cnt[k*16 +: 16] = cnt_r;
`else
    // Pulse counters are not built in this configuration
`endif
  end

endmodule

// File: doc/jtframe_multi_cen.md
JTFRAME_MULTI_CEN -- requirements
Module: jtframe_multi_cen

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter WC, default 10: width of each channel's n and m values and of its accumulator.
REQ-003 SHALL have parameter INIT_N, default all ones-per-channel (n=1 in every WC slice), packed NCH*WC: reset numerators, channel k in bits [k*WC +: WC].
REQ-004 SHALL have parameter INIT_M, default m=4 in every WC slice, packed NCH*WC: reset denominators, same packing as INIT_N.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port pause, input, 1: when high, all channels hold their state and emit no pulses.
REQ-008 SHALL have port cfg_we, input, 1: write strobe for the configuration port, one write per cycle.
REQ-009 SHALL have port cfg_ch, input, 3: target channel of a write; writes to channels >= NCH are ignored.
REQ-010 SHALL have port cfg_n, input, WC: new numerator for the target channel.
REQ-011 SHALL have port cfg_m, input, WC: new denominator for the target channel.
REQ-012 SHALL have port cfg_pend, output, NCH: per-channel flag that a written ratio is waiting to take effect.
REQ-013 SHALL have port cen, output, NCH: main clock-enable pulse, one cycle wide, at average rate f_clk*n/m.
REQ-014 SHALL have port cen2, output, NCH: half-rate enable, asserted on every second cen pulse of the channel.
REQ-015 SHALL have port cenb, output, NCH: mid-period enable, one cycle wide, at the half-way point between cen pulses.

Function
REQ-016 Each channel SHALL compute sum = acc + n each unpaused cycle, WC+1 bits wide, with no overflow possible.
REQ-017 If sum >= m, the channel SHALL load acc = sum - m and assert cen for that cycle; otherwise it SHALL load acc = sum.
REQ-018 cenb SHALL assert in a cycle where acc < m/2 and sum >= m/2 (m/2 truncated) and cen is not asserted that cycle.
REQ-019 cen2 SHALL be cen gated by a per-channel toggle; the toggle SHALL flip on each cen, and cen2 SHALL fire on the first cen after reset.
REQ-020 If m = 0 or n = 0, the channel SHALL be silent: acc holds, and cen, cen2 and cenb stay 0.
REQ-021 If n >= m (with m != 0), cen SHALL assert every unpaused cycle, acc SHALL be forced to 0, and cenb SHALL stay 0.
REQ-022 A cfg write SHALL store n and m in the channel's shadow registers and set cfg_pend[ch] on the next edge.
REQ-023 A pending ratio SHALL be applied on the cycle its channel asserts cen, or immediately if the channel is silent per REQ-020.
REQ-024 Applying a ratio SHALL clear acc to 0, reset the cen2 toggle, and clear cfg_pend; that cycle's cen is still issued using the old ratio.
REQ-025 A second write before the first is applied SHALL overwrite the shadow registers, and cfg_pend SHALL stay set.
REQ-026 A write in the same cycle as an apply SHALL win: cfg_pend SHALL remain 1 holding the new values.
REQ-027 While pause is high, acc, the cen2 toggles and pending applies SHALL freeze; cfg writes SHALL still be accepted.
REQ-028 All outputs SHALL be registered, with cen, cen2 and cenb asserted one cycle after the accumulator decision.

Reset
REQ-029 rst SHALL asynchronously clear acc, the cen2 toggles, cfg_pend, cen, cen2 and cenb to 0, and load the n/m registers and shadows from INIT_N/INIT_M.
REQ-030 A reset during operation, including while a ratio is pending, SHALL discard the pending ratio.
REQ-031 After rst deasserts, the first possible cen pulse SHALL be the one following the ceil(m/n)-th unpaused edge.

Configuration
REQ-032 Macro JTFRAME_MULTI_CEN_CNT_EN SHALL, when defined, add output cen_cnt (NCH*16): per-channel wrapping count of cen pulses, cleared by rst, plus input cnt_clr (1), which clears all counts synchronously.
REQ-033 Without JTFRAME_MULTI_CEN_CNT_EN, cen_cnt and cnt_clr SHALL be absent and the behaviour SHALL be otherwise identical.

Structure
REQ-034 Constants for the maximum channel count (8) and the cfg_ch width (3) SHALL live in package jtframe_cen_pkg.
REQ-035 The per-channel accumulator, shadow and apply logic SHALL be a sub-module jtframe_cen_ch, instantiated NCH times by a generate loop.

Verification
REQ-036 Defaults (n=1, m=4): cen every 4th cycle, cen2 every 8th, cenb 2 cycles after each cen.
REQ-037 Channel 0 set to n=143, m=450 over 4500 unpaused cycles -> exactly 1430 cen and 715 cen2 pulses.
REQ-038 Write n=1, m=8 mid-period -> cfg_pend=1 until the next old-ratio cen, then the period is 8 from that pulse.
REQ-039 n=5, m=5 -> cen every cycle; m=0 -> no pulses, and a subsequent write is applied the next cycle.
REQ-040 pause high for 10 cycles -> zero pulses, and the phase resumes unchanged afterwards.
REQ-041 rst asserted mid-period with a write pending -> all outputs 0 at once, cfg_pend=0, and INIT ratios restored.
